// File: rtl/exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic ops, iterative shifter
// moving SHIFT_STEP bit positions per cycle, valid/ready handshake on both sides.
module exec_unit #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUResult,
  output logic        Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  localparam logic [1:0] KIND_SLL = 2'd0;
  localparam logic [1:0] KIND_SRL = 2'd1;
  localparam logic [1:0] KIND_SRA = 2'd2;

  state_t      state_reg;
  logic [31:0] work_reg;
  logic [5:0]  rem_reg;
  logic [1:0]  kind_reg;

  logic        accept;
  logic        is_shift;
  logic [4:0]  shamt;
  logic [1:0]  op_kind;
  logic [31:0] op_result;
  logic [5:0]  step_amt;
  logic [5:0]  rem_next;
  logic [31:0] work_next;

  assign shamt    = SrcB[4:0];
  assign in_ready = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Result of an op that completes at the accept edge; shifts only land here when shamt is 0.
  always_comb begin
    op_result = 32'd0;
    is_shift  = 1'b0;
    op_kind   = KIND_SLL;
    case (ALUControl)
      4'b0000: op_result = SrcA + SrcB;
      4'b0001: op_result = SrcA - SrcB;
      4'b0010: op_result = SrcA & SrcB;
      4'b0011: op_result = SrcA | SrcB;
      4'b0100: op_result = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
      4'b0101: begin
        op_result = SrcA;
        is_shift  = 1'b1;
        op_kind   = KIND_SLL;
      end
      4'b0110: op_result = (SrcA < SrcB) ? 32'd1 : 32'd0;
      4'b0111: op_result = SrcA ^ SrcB;
      4'b1000: begin
        op_result = SrcA;
        is_shift  = 1'b1;
        op_kind   = KIND_SRL;
      end
      4'b1001: begin
        op_result = SrcA;
        is_shift  = 1'b1;
        op_kind   = KIND_SRA;
      end
      default: op_result = 32'd0;
    endcase
  end

  // One shifter iteration; the final iteration may be shorter than SHIFT_STEP.
  always_comb begin
    step_amt = (rem_reg < STEP) ? rem_reg : STEP;
    rem_next = rem_reg - step_amt;
    case (kind_reg)
      KIND_SRL: work_next = work_reg >> step_amt;
      KIND_SRA: work_next = $signed(work_reg) >>> step_amt;
      default:  work_next = work_reg << step_amt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= 32'd0;
      Zero      <= 1'b0;
      work_reg  <= 32'd0;
      rem_reg   <= 6'd0;
      kind_reg  <= KIND_SLL;
    end else if (accept) begin
      if (is_shift && (shamt != 5'd0)) begin
        state_reg <= SHIFT;
        out_valid <= 1'b0;
        work_reg  <= SrcA;
        rem_reg   <= {1'b0, shamt};
        kind_reg  <= op_kind;
      end else begin
        state_reg <= DONE;
        out_valid <= 1'b1;
        ALUResult <= op_result;
        Zero      <= (op_result == 32'd0);
      end
    end else begin
      case (state_reg)
        SHIFT: begin
          work_reg <= work_next;
          rem_reg  <= rem_next;
          if (rem_next == 6'd0) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
            ALUResult <= work_next;
            Zero      <= (work_next == 32'd0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed corner cases, backpressure, mid-shift reset,
// then randomized ops checked against a plain-arithmetic reference model.
module tb_exec_unit;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;

  always #5 clk = ~clk;

  exec_unit #(.SHIFT_STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero(Zero)
  );

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    logic [3:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   head_seen = 1'b0;
  bit   or_force = 1'b1;
  bit   or_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: forced during directed tests, random otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = or_force ? or_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:    return a << sh;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a ^ b;
      4'd8:    return a >> sh;
      4'd9:    return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((c == 4'd5 || c == 4'd8 || c == 4'd9) && sh != 0)
      return 1 + (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int waits);
    exp_t e;
    bit   done;
    bit   got;
    done  = 1'b0;
    waits = 0;
    ALUControl = c;
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    while (!done) begin
      got = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        e.res  = model(c, a, b);
        e.lat  = latency(c, b);
        e.acc  = cyc;
        e.code = c;
        got  = 1'b1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: waited %0d cycles, expected accept within 200", waits);
          done = 1'b1;
        end
      end
      @(posedge clk);
      if (got) sb.push_back(e);
      #1;
    end
    in_valid = 1'b0;
    ALUControl = 4'($urandom);
    SrcA = $urandom;
    SrcB = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (k != 0) #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      head_seen = 1'b0;
      check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end else begin
      check("in_ready", {31'd0, in_ready},
            {31'd0, out_valid ? out_ready : (sb.size() == 0)});
      if (sb.size() == 0) begin
        check("no_stale_valid", {31'd0, out_valid}, 32'd0);
      end else if (out_valid) begin
        if (!head_seen) begin
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          head_seen = 1'b1;
        end
        if (out_ready) begin
          check("result", ALUResult, sb[0].res);
          check("zero", {31'd0, Zero}, {31'd0, sb[0].res == 32'd0});
          $display("txn code=%h result=%h zero=%b lat=%0d", sb[0].code, ALUResult, Zero, sb[0].lat);
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int          w;
    logic [31:0] hold;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    or_force = 1'b1;
    or_val = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases, issued back to back.
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, w);
    issue(4'd4, 32'h8000_0000, 32'd1, w);
    issue(4'd6, 32'h8000_0000, 32'd1, w);
    issue(4'd9, 32'h8000_0000, 32'h0000_0023, w);
    issue(4'd5, 32'd1, 32'd31, w);
    issue(4'd8, 32'hABCD_1234, 32'hFFFF_FFE0, w);
    issue(4'd8, 32'h8000_0001, 32'd5, w);
    issue(4'hC, 32'd5, 32'd6, w);
    issue(4'd1, 32'd3, 32'd3, w);
    drain();

    // Backpressure on an XOR result, then accept on the cycle ready rises.
    or_val = 1'b0;
    a = $urandom;
    b = $urandom;
    hold = model(4'd7, a, b);
    issue(4'd7, a, b, w);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold", ALUResult, hold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    or_val = 1'b1;
    issue(4'd0, $urandom, $urandom, w);
    check("b2b_accept_waits", 32'(w), 32'd0);
    drain();

    // Reset in the middle of a 20-position shift.
    issue(4'd5, $urandom, 32'd20, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", ALUResult, 32'd0);
    check("midrst_zero", {31'd0, Zero}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_result", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with random consumer backpressure.
    or_force = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0:       c = 4'd5;
          1:       c = 4'd8;
          default: c = 4'd9;
        endcase
      end else begin
        c = 4'($urandom_range(0, 15));
      end
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      issue(c, a, b, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter SHIFT_STEP, default 1, the number of bit positions shifted per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation on ALUControl/SrcA/SrcB is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 The block SHALL have port ALUControl, input, 4 bits: operation code from the ALU decoder.
REQ-007 The block SHALL have ports SrcA and SrcB, input, 32 bits each: operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: ALUResult and Zero hold a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port ALUResult, output, 32 bits: registered result.
REQ-011 The block SHALL have port Zero, output, 1 bit: registered flag, high when ALUResult == 0.

Function
REQ-012 The block SHALL decode ALUControl as follows: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT, 0101 SLL, 0110 SLTU, 0111 XOR, 1000 SRL, 1001 SRA.
REQ-013 The block SHALL treat codes 1010-1111 as single-cycle operations with result 0 and Zero 1.
REQ-014 An operation SHALL be accepted on a cycle with in_valid && in_ready; operands and code are captured at that edge and later input changes have no effect.
REQ-015 The block SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-016 In IDLE, accepting a single-cycle op (ADD/SUB/AND/OR/XOR/SLT/SLTU/unsupported) SHALL go to DONE with the result registered; out_valid is high on the next cycle.
REQ-017 Accepting a shift with shamt = SrcB[4:0] == 0 SHALL go to DONE with ALUResult = SrcA.
REQ-018 Accepting a shift with shamt > 0 SHALL go to SHIFT, loading SrcA into a working register and shamt into a remaining count.
REQ-019 In SHIFT, each cycle SHALL shift the working register by min(SHIFT_STEP, remaining) positions and decrement remaining by the same amount; the block enters DONE when remaining reaches 0.
REQ-020 Shift latency SHALL be exactly 1 + ceil(shamt / SHIFT_STEP) cycles from the accept edge to out_valid high.
REQ-021 SLL SHALL zero-fill; SRL SHALL zero-fill; SRA SHALL replicate bit 31 of the original SrcA; SrcB[31:5] SHALL be ignored.
REQ-022 Arithmetic SHALL be modulo 2^32 with no overflow flag; SLT compares signed; SLTU compares unsigned; both produce 32'd1 or 32'd0.
REQ-023 In DONE, out_valid SHALL be high, and ALUResult/Zero SHALL be held stable until out_valid && out_ready.
REQ-024 in_ready SHALL be high in IDLE, high in DONE only when out_ready is high, and low in SHIFT.
REQ-025 In DONE with out_ready high and a new accept, the block SHALL process the new op as from IDLE in the same edge, giving back-to-back single-cycle throughput of one op per cycle.
REQ-026 In DONE with out_ready high and no new accept, the block SHALL return to IDLE and drop out_valid.
REQ-027 Zero SHALL always equal (ALUResult == 0) whenever out_valid is high.

Reset
REQ-028 When rst is high at a clock edge, the block SHALL set state to IDLE, out_valid to 0, ALUResult to 0, Zero to 0, and clear the working register and remaining count, regardless of state, including mid-SHIFT or in DONE.
REQ-029 While rst is high, in_ready SHALL be 0 and no operation SHALL be accepted; in_ready rises the cycle after rst falls.

Verification
REQ-030 ADD with SrcA=32'hFFFFFFFF, SrcB=1, out_ready=1 -> one cycle later out_valid=1, ALUResult=0, Zero=1.
REQ-031 SLT vs SLTU with SrcA=32'h80000000, SrcB=1 -> SLT gives 1 and SLTU gives 0, each with one-cycle latency.
REQ-032 SRA with SHIFT_STEP=1, SrcA=32'h80000000, SrcB=32'h00000023 (shamt 3) -> in_ready low 3 cycles, out_valid at accept+4, ALUResult=32'hF0000000.
REQ-033 SLL with SHIFT_STEP=4, SrcA=1, shamt=31 -> out_valid at accept+1+8, ALUResult=32'h80000000.
REQ-034 Backpressure: out_ready=0 for 5 cycles after an XOR result -> ALUResult stable, in_ready low, and a back-to-back op is accepted on the cycle out_ready rises.
REQ-035 Assert rst during SHIFT with shamt=20 -> next cycle state IDLE, out_valid=0, ALUResult=0, and no stale result ever appears.
